// File: rtl/alarm_monitor_stage.sv
// alarm_monitor_stage: tags each adder result as clean/erroneous from the
// per-layer alarm vector, buffers it in a 2-entry FIFO behind valid/ready,
// counts soft errors and enters FAULT after FAULT_THRESHOLD consecutive
// erroneous accepted words, holding off upstream until clear_fault.
//
// Optional build macro: ALARM_MONITOR_DROP_EN
//   defined   - erroneous words complete the handshake but are not stored;
//               out_err is tied low.
//   undefined - every accepted word is stored with its error tag.
//
// state | meaning
// RUN   | accepting words while the FIFO has room
// FAULT | upstream held off (in_ready=0); FIFO drains; counters hold

module alarm_monitor_stage #(
  parameter int WORD_WIDTH      = 4,
  parameter int LAYERS          = 1,
  parameter int FAULT_THRESHOLD = 3,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] sum_in,
  input  logic [LAYERS-1:0]     alarm_signals,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  fault,
  output logic [CNT_WIDTH-1:0]  err_count,
  input  logic                  clear_fault
);

`ifdef ALARM_MONITOR_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  localparam logic [7:0] THRESH = 8'(FAULT_THRESHOLD);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t                state;
  logic [1:0]            occ;
  logic [WORD_WIDTH-1:0] head_data;
  logic [WORD_WIDTH-1:0] tail_data;
  logic                  head_err;
  logic                  tail_err;
  logic [7:0]            consec;
  logic [7:0]            consec_inc;
  logic                  word_err;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign word_err   = |alarm_signals;
  // Ready is independent of out_ready: a full FIFO never takes a word even
  // when the head pops on the same edge.
  assign in_ready   = (state == RUN) && (occ != 2'd2);
  assign accept     = in_valid && in_ready;
  assign push       = accept && !(DROP_EN && word_err);
  assign out_valid  = (occ != 2'd0);
  assign pop        = out_valid && out_ready;
  assign out_data   = head_data;
  assign out_err    = DROP_EN ? 1'b0 : head_err;
  assign fault      = (state == FAULT);
  assign consec_inc = (consec == 8'hFF) ? consec : consec + 8'd1;

  // Two-entry FIFO: head register drives the outputs directly, tail holds
  // the second word. Head keeps its last value when the FIFO empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      head_data <= '0;
      head_err  <= 1'b0;
      tail_data <= '0;
      tail_err  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= sum_in;
            head_err  <= word_err;
            occ       <= 2'd1;
          end else begin
            tail_data <= sum_in;
            tail_err  <= word_err;
            occ       <= 2'd2;
          end
        end
        2'b01: begin
          if (occ == 2'd2) begin
            head_data <= tail_data;
            head_err  <= tail_err;
          end
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // Only reachable at occupancy 1: new word replaces the popped head.
          head_data <= sum_in;
          head_err  <= word_err;
        end
        default: ;
      endcase
    end
  end

  // Error counters and RUN/FAULT sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      consec    <= 8'd0;
      err_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            if (word_err) begin
              if (err_count != '1) err_count <= err_count + 1'b1;
              consec <= consec_inc;
              if (consec_inc == THRESH) state <= FAULT;
            end else begin
              consec <= 8'd0;
            end
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state  <= RUN;
            consec <= 8'd0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_monitor_stage.sv
// Bench for alarm_monitor_stage: directed scenarios with literal checks plus
// a randomized phase, all compared every cycle against a queue-based model.
module tb_alarm_monitor_stage;
  localparam int W  = 4;
  localparam int L  = 1;
  localparam int TH = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  sum_in;
  logic [L-1:0]  alarm_signals;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic          fault;
  logic [CW-1:0] err_count;
  logic          clear_fault;

  int checks = 0;
  int errors = 0;

  alarm_monitor_stage #(
    .WORD_WIDTH(W), .LAYERS(L), .FAULT_THRESHOLD(TH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .alarm_signals(alarm_signals), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .fault(fault), .err_count(err_count), .clear_fault(clear_fault)
  );

  always #5 clk = ~clk;

  // Model: FIFO as a queue of {data, err}, fault flag, plain integer counters.
  logic [W:0]   mq[$];
  bit           m_fault;
  int           m_cnt;
  int           m_consec;
  logic [W-1:0] m_last_d;
  logic         m_last_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fault  = 1'b0;
    m_cnt    = 0;
    m_consec = 0;
    m_last_d = '0;
    m_last_e = 1'b0;
  endtask

  task automatic compare_all();
    bit mv;
    mv = (mq.size() > 0);
    if (mv) {m_last_d, m_last_e} = mq[0];
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("out_data",  32'(out_data),  32'(m_last_d));
    chk("out_err",   32'(out_err),   32'(m_last_e));
    chk("in_ready",  32'(in_ready),  32'(!m_fault && mq.size() < 2));
    chk("fault",     32'(fault),     32'(m_fault));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  // Called at a negedge: check, drive this cycle's inputs, advance the model
  // by one edge, and return at the next negedge.
  task automatic step(input bit v, input logic [W-1:0] d, input logic [L-1:0] a,
                      input bit ordy, input bit clr);
    bit e, rdy, acc, pp;
    compare_all();
    in_valid = v; sum_in = d; alarm_signals = a; out_ready = ordy; clear_fault = clr;
    e   = |a;
    rdy = !m_fault && mq.size() < 2;
    acc = v && rdy;
    pp  = (mq.size() > 0) && ordy;
    if (pp) void'(mq.pop_front());
    if (m_fault) begin
      if (clr) begin
        m_fault  = 1'b0;
        m_consec = 0;
      end
    end else if (acc) begin
      if (e) begin
        m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_consec = (m_consec < 255) ? m_consec + 1 : 255;
        if (m_consec == TH) m_fault = 1'b1;
      end else begin
        m_consec = 0;
      end
`ifdef ALARM_MONITOR_DROP_EN
      if (!e) mq.push_back({d, 1'b0});
`else
      mq.push_back({d, e});
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; sum_in = '0; alarm_signals = '0;
    out_ready = 0; clear_fault = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_fault",     32'(fault),     32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;

    // Single clean word appears the cycle after the accept.
    step(1, 4'h5, 1'b0, 1, 0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data",  32'(out_data),  32'h5);
    chk("t1_err",   32'(out_err),   32'd0);
    chk("t1_cnt",   32'(err_count), 32'd0);
    step(0, 4'h0, 1'b0, 1, 0);

    // Fill to 2 with out_ready low; 3 is held off until a slot frees.
    step(1, 4'h1, 1'b0, 0, 0);
    step(1, 4'h2, 1'b0, 0, 0);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    chk("t2_head1",      32'(out_data), 32'h1);
    step(1, 4'h3, 1'b0, 1, 0);
    chk("t2_head2",      32'(out_data), 32'h2);
    step(1, 4'h3, 1'b0, 1, 0);
    chk("t2_head3",      32'(out_data), 32'h3);
    step(0, 4'h0, 1'b0, 1, 0);
    chk("t2_empty",      32'(out_valid), 32'd0);

    // Three consecutive errors trip FAULT.
    step(1, 4'h7, 1'b1, 1, 0);
    step(1, 4'h8, 1'b1, 1, 0);
    chk("t3_no_fault_yet", 32'(fault), 32'd0);
    step(1, 4'h9, 1'b1, 1, 0);
    chk("t3_fault",   32'(fault),     32'd1);
    chk("t3_cnt",     32'(err_count), 32'd3);
    chk("t3_ready",   32'(in_ready),  32'd0);
`ifndef ALARM_MONITOR_DROP_EN
    chk("t3_out_err", 32'(out_err),   32'd1);
    chk("t3_data",    32'(out_data),  32'h9);
`endif
    step(1, 4'hA, 1'b1, 1, 0);
    chk("t3_hold_cnt", 32'(err_count), 32'd3);

    // Clear, then err,err,clean,err,err stays out of FAULT; one more trips it.
    step(0, 4'h0, 1'b0, 1, 1);
    chk("t5_fault_clr", 32'(fault),    32'd0);
    chk("t5_ready",     32'(in_ready), 32'd1);
    step(1, 4'h1, 1'b1, 1, 0);
    step(1, 4'h2, 1'b1, 1, 0);
    chk("t4_fault_a", 32'(fault),     32'd0);
    chk("t4_cnt_a",   32'(err_count), 32'd5);
    step(1, 4'h3, 1'b0, 1, 0);
    step(1, 4'h4, 1'b1, 1, 0);
    step(1, 4'h5, 1'b1, 1, 0);
    chk("t4_fault_b", 32'(fault),     32'd0);
    chk("t4_cnt_b",   32'(err_count), 32'd7);
    step(1, 4'h6, 1'b1, 1, 0);
    chk("t4_fault_c", 32'(fault),     32'd1);
    chk("t4_cnt_c",   32'(err_count), 32'd8);
    step(0, 4'h0, 1'b0, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 70),
           W'($urandom),
           L'(($urandom_range(0, 99) < 30) ? 1 : 0),
           ($urandom_range(0, 99) < 65),
           ($urandom_range(0, 99) < 10));
    end

    // Asynchronous reset with two words buffered.
    step(0, 4'h0, 1'b0, 1, 1);
    step(0, 4'h0, 1'b0, 1, 0);
    step(0, 4'h0, 1'b0, 1, 0);
    step(1, 4'hC, 1'b0, 0, 0);
    step(1, 4'hD, 1'b0, 0, 0);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_ready", 32'(in_ready),  32'd0);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid",    32'(out_valid), 32'd0);
    chk("t6_fault",    32'(fault),     32'd0);
    chk("t6_cnt",      32'(err_count), 32'd0);
    chk("t6_data",     32'(out_data),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'hE, 1'b0, 1, 0);
    chk("t6_after_data", 32'(out_data), 32'hE);
    for (int i = 0; i < 20; i++)
      step(($urandom_range(0, 1) == 1), W'($urandom), L'($urandom_range(0, 1)), 1, 0);
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
